pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter WDT_LIMIT, default 255, consecutive-stall-cycle count that triggers the watchdog error.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port stallreq_id_i  input  1  load-use hazard stall request from decode.
REQ-005 SHALL have port stallreq_exe_i  input  1  multi-cycle execute (M-extension divide) busy.
REQ-006 SHALL have port stallreq_mem_i  input  1  data-bus wait from memory stage.
REQ-007 SHALL have port jump_flag_i  input  1  taken branch/jump resolved in execute.
REQ-008 SHALL have port jump_addr_i  input  32  jump target.
REQ-009 SHALL have port halt_req_i  input  1  debug halt request, level.
REQ-010 SHALL have port resume_i  input  1  debug resume, one-cycle pulse.
REQ-011 SHALL have port stall_o  output  6  hold vector: bit0 pc, bit1 if_id, bit2 id_exe, bit3 exe_mem, bit4 mem_wb, bit5 wb.
REQ-012 SHALL have port flush_o  output  1  clear if_id and id_exe to NOP.
REQ-013 SHALL have port jump_flag_o / jump_addr_o  output  1 / 32  PC redirect.
REQ-014 SHALL have ports halted_o, wdt_err_o  output  1 each  status.
REQ-015 SHALL have ports stall_cnt_o, flush_cnt_o  output  32 each  saturating performance counters.

Function
REQ-016 SHALL implement FSM states RUN, HALT, ERROR; stall_o, flush_o and jump outputs combinational from state and inputs.
REQ-017 In RUN, stall priority: mem -> 6'b011111; else exe -> 6'b001111; else id -> 6'b000111; else 6'b000000.
REQ-018 In RUN, jump accepted only when stallreq_mem_i=0 and stallreq_exe_i=0: flush_o=1, jump_flag_o=1, jump_addr_o=jump_addr_i, same cycle.
REQ-019 Jump and stallreq_id_i in the same cycle: jump wins, stall_o=0 (hazard instruction killed by flush).
REQ-020 Jump while mem/exe stall active: ignored that cycle; flush_o=0, jump_flag_o=0.
REQ-021 jump_addr_o SHALL be 0 whenever jump_flag_o=0.
REQ-022 Watchdog counter SHALL increment each RUN cycle with stall_o!=0 and clear on any RUN cycle with stall_o=0.
REQ-023 When watchdog counter reaches WDT_LIMIT, FSM SHALL enter ERROR next cycle.
REQ-024 ERROR: stall_o=6'b111111, flush_o=0, wdt_err_o=1; sticky until reset; all inputs ignored.
REQ-025 RUN -> HALT when halt_req_i=1, no stall request and no jump that cycle; else halt stays pending (level) until eligible.
REQ-026 HALT: stall_o=6'b111111, halted_o=1, watchdog counter frozen; resume_i=1 -> RUN next cycle; jump_flag_i ignored.
REQ-027 stall_cnt_o SHALL increment on each cycle with stall_o!=0 in RUN; flush_cnt_o on each cycle with flush_o=1; both saturate at 32'hFFFFFFFF.

Reset
REQ-028 While rst_n_i=0: state RUN, stall_o=0, flush_o=0, jump_flag_o=0, jump_addr_o=0, halted_o=0, wdt_err_o=0, counters 0, regardless of inputs.
REQ-029 Reset assertion mid-stall or in HALT/ERROR SHALL take effect immediately (asynchronous); deassertion resumes in RUN at next edge.

Structure
REQ-030 Stall-vector encodings, FSM state encoding and WDT_LIMIT default SHALL live in the shared defines file beside NOP/ZERO_REG.
REQ-031 One sub-module, sat_counter (32-bit saturating increment with enable), SHALL be instantiated twice for the performance counters.

Verification
REQ-032 stallreq_id_i=1 one cycle -> stall_o=6'b000111 that cycle, stall_cnt_o +1, then 0.
REQ-033 stallreq_exe_i=1 and jump_flag_i=1 for 3 cycles, then exe drops with jump held -> flush_o=1 only on cycle 4, jump_addr_o=jump_addr_i (e.g. 32'h00000100).
REQ-034 stallreq_id_i=1 with jump_flag_i=1 -> stall_o=0, flush_o=1, flush_cnt_o=1.
REQ-035 stallreq_mem_i held, WDT_LIMIT=4 -> 4 stall cycles, then wdt_err_o=1, stall_o=6'b111111 until rst_n_i low.
REQ-036 halt_req_i=1 during exe stall -> HALT entered only after stall clears; resume_i pulse -> RUN next cycle, halted_o=0.
REQ-037 rst_n_i dropped mid-HALT between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: instruction/register constants, hold-vector
// encodings, controller state encoding and the default watchdog limit.
package pipe_ctrl_pkg;

  // Canonical NOP (addi x0, x0, 0) and the hard-wired zero register index
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [4:0]  ZERO_REG = 5'd0;

  // Hold vector bit order: bit0 pc, bit1 if_id, bit2 id_exe, bit3 exe_mem, bit4 mem_wb, bit5 wb
  localparam int unsigned STALL_W = 6;
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EXE  = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

  // Consecutive stall cycles tolerated before declaring a hang
  localparam int unsigned WDT_LIMIT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Increment when enabled unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall/flush arbitration, PC redirect, debug halt,
// stall watchdog and performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WDT_LIMIT = WDT_LIMIT_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               stallreq_id_i,
  input  logic               stallreq_exe_i,
  input  logic               stallreq_mem_i,
  input  logic               jump_flag_i,
  input  logic [31:0]        jump_addr_i,
  input  logic               halt_req_i,
  input  logic               resume_i,
  output logic [STALL_W-1:0] stall_o,
  output logic               flush_o,
  output logic               jump_flag_o,
  output logic [31:0]        jump_addr_o,
  output logic               halted_o,
  output logic               wdt_err_o,
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        flush_cnt_o
);

  state_e      state_q, state_d;
  logic [31:0] wdt_q, wdt_d;
  logic        jump_ok;
  logic        any_stallreq;

  // A jump can only redirect when the older stages are not frozen
  assign jump_ok      = jump_flag_i && !stallreq_mem_i && !stallreq_exe_i;
  assign any_stallreq = stallreq_id_i || stallreq_exe_i || stallreq_mem_i;

  // State and watchdog registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_RUN;
      wdt_q   <= '0;
    end else begin
      state_q <= state_d;
      wdt_q   <= wdt_d;
    end
  end

  // Next state: watchdog trips to ERROR, halt waits for a quiet cycle, resume returns to RUN
  always_comb begin
    state_d = state_q;
    wdt_d   = wdt_q;
    case (state_q)
      ST_RUN: begin
        if (stall_o != STALL_NONE) begin
          wdt_d = wdt_q + 32'd1;
          if (wdt_d >= 32'(WDT_LIMIT)) begin
            state_d = ST_ERROR;
          end
        end else begin
          wdt_d = '0;
          if (halt_req_i && !any_stallreq && !jump_flag_i) begin
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        if (resume_i) begin
          state_d = ST_RUN;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_RUN;
        wdt_d   = '0;
      end
    endcase
  end

  // Outputs: forced quiet during reset; a jump kills a decode hazard rather than stalling for it
  always_comb begin
    stall_o     = STALL_NONE;
    flush_o     = 1'b0;
    jump_flag_o = 1'b0;
    jump_addr_o = '0;
    halted_o    = 1'b0;
    wdt_err_o   = 1'b0;
    if (rst_n_i) begin
      case (state_q)
        ST_RUN: begin
          if (stallreq_mem_i) begin
            stall_o = STALL_MEM;
          end else if (stallreq_exe_i) begin
            stall_o = STALL_EXE;
          end else if (!jump_ok && stallreq_id_i) begin
            stall_o = STALL_ID;
          end
          if (jump_ok) begin
            flush_o     = 1'b1;
            jump_flag_o = 1'b1;
            jump_addr_o = jump_addr_i;
          end
        end
        ST_HALT: begin
          stall_o  = STALL_ALL;
          halted_o = 1'b1;
        end
        ST_ERROR: begin
          stall_o   = STALL_ALL;
          wdt_err_o = 1'b1;
        end
        default: begin
          stall_o = STALL_NONE;
        end
      endcase
    end
  end

  logic stall_cnt_en;
  assign stall_cnt_en = (state_q == ST_RUN) && (stall_o != STALL_NONE);

  sat_counter #(.W(32)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (stall_cnt_en),
    .cnt_o   (stall_cnt_o)
  );

  sat_counter #(.W(32)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (flush_o),
    .cnt_o   (flush_cnt_o)
  );

endmodule
